// File: rtl/ahb_lite_master_if.sv
// ---------------------------------------------------------------------------
// ahb_lite_master_if
//  AHB-Lite bus signal bundle between the single-outstanding initiator and a
//  slave (or a bench acting as one).
//  Parameter: ADDR_W - width of HADDR.
//  Signals:
//   HADDR  [ADDR_W] address-phase address        (master -> slave)
//   HTRANS [2]      00 IDLE / 10 NONSEQ          (master -> slave)
//   HWRITE          address-phase direction      (master -> slave)
//   HSIZE  [3]      address-phase size           (master -> slave)
//   HBURST [3]      always SINGLE                (master -> slave)
//   HWDATA [32]     data-phase write data        (master -> slave)
//   HRDATA [32]     data-phase read data         (slave -> master)
//   HREADY          transfer complete            (slave -> master)
//   HRESP  [2]      00 OKAY, anything else error (slave -> master)
// ---------------------------------------------------------------------------
interface ahb_lite_master_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic [1:0]        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master
//  Single-outstanding AHB-Lite initiator. Takes one request at a time from a
//  simple core port, runs it as a SINGLE NONSEQ transfer, steers byte lanes
//  in both directions and reports completion, error and read data to the core.
//  FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE (misaligned: IDLE -> RESP).
//  Every output is a register.
//
//  Optional feature macro: AHB_MST_TIMEOUT_EN
//   defined   - HREADY-low cycles in ADDR/DATA are counted; reaching
//               TIMEOUT_CYC abandons the transfer and reports an error.
//   undefined - the master waits on HREADY indefinitely.
//
//  Parameters: ADDR_W (address width), TIMEOUT_CYC (wait-cycle limit).
//  Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   cpu_req/wr/size      request strobe (held until cpu_done), direction, size
//   cpu_addr/wdata       byte address, right-justified write data
//   cpu_busy             high whenever the FSM is not IDLE
//   cpu_done/err/rdata   one-cycle completion pulse with status and read data
//   ahb                  AHB-Lite bus (master modport)
// ---------------------------------------------------------------------------
module ahb_lite_master #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [2:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  ahb_lite_master_if.master ahb
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] haddr_q,     haddr_d;
  logic [1:0]        htrans_q,    htrans_d;
  logic              hwrite_q,    hwrite_d;
  logic [2:0]        hsize_q,     hsize_d;
  logic [31:0]       hwdata_q,    hwdata_d;
  logic [31:0]       wdata_q,     wdata_d;     // lane-replicated write data
  logic              err_acc_q,   err_acc_d;   // sticky HRESP error over DATA
  logic              cpu_busy_q,  cpu_busy_d;
  logic              cpu_done_q,  cpu_done_d;
  logic              cpu_err_q,   cpu_err_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;

  logic        misaligned;
  logic        resp_err;
  logic [31:0] lane_wdata;
  logic [31:0] rd_shift;
  logic [31:0] rd_extract;

  // Halfwords need addr[0]=0, words addr[1:0]=0; sizes above word are refused.
  assign misaligned = (cpu_size > 3'b010) ||
                      ((cpu_size == 3'b001) && cpu_addr[0]) ||
                      ((cpu_size == 3'b010) && (cpu_addr[1:0] != 2'b00));

  assign resp_err = (ahb.HRESP != 2'b00);

  always_comb begin
    case (cpu_size)
      3'b000:  lane_wdata = {4{cpu_wdata[7:0]}};
      3'b001:  lane_wdata = {2{cpu_wdata[15:0]}};
      default: lane_wdata = cpu_wdata;
    endcase
  end

  // Bring the addressed lane down to bit 0, then keep only the transfer size.
  assign rd_shift = ahb.HRDATA >> {haddr_q[1:0], 3'b000};

  always_comb begin
    case (hsize_q)
      3'b000:  rd_extract = {24'h0, rd_shift[7:0]};
      3'b001:  rd_extract = {16'h0, rd_shift[15:0]};
      default: rd_extract = rd_shift;
    endcase
  end

`ifdef AHB_MST_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             stalled;

  assign stalled = !ahb.HREADY && ((state_q == ST_ADDR) || (state_q == ST_DATA));
`endif

  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    err_acc_d   = err_acc_q;
    cpu_busy_d  = cpu_busy_q;
    cpu_done_d  = cpu_done_q;
    cpu_err_d   = cpu_err_q;
    cpu_rdata_d = cpu_rdata_q;

    case (state_q)
      ST_IDLE: begin
        cpu_done_d = 1'b0;
        cpu_err_d  = 1'b0;
        if (cpu_req) begin
          cpu_busy_d = 1'b1;
          if (misaligned) begin
            // Refused without touching the bus.
            state_d     = ST_RESP;
            cpu_done_d  = 1'b1;
            cpu_err_d   = 1'b1;
            cpu_rdata_d = '0;
          end else begin
            state_d   = ST_ADDR;
            htrans_d  = TR_NONSEQ;
            haddr_d   = cpu_addr;
            hwrite_d  = cpu_wr;
            hsize_d   = cpu_size;
            wdata_d   = lane_wdata;
            err_acc_d = 1'b0;
          end
        end
      end

      ST_ADDR: begin
        if (ahb.HREADY) begin
          state_d  = ST_DATA;
          htrans_d = TR_IDLE;
          if (hwrite_q) begin
            hwdata_d = wdata_q;
          end
        end
      end

      ST_DATA: begin
        // Error seen on any DATA cycle, including wait cycles, sticks.
        err_acc_d = err_acc_q | resp_err;
        if (ahb.HREADY) begin
          state_d     = ST_RESP;
          cpu_done_d  = 1'b1;
          cpu_err_d   = err_acc_q | resp_err;
          cpu_rdata_d = hwrite_q ? 32'h0 : rd_extract;
        end
      end

      default: begin  // ST_RESP
        state_d    = ST_IDLE;
        cpu_busy_d = 1'b0;
        cpu_done_d = 1'b0;
        cpu_err_d  = 1'b0;
      end
    endcase
  end

`ifdef AHB_MST_TIMEOUT_EN
  // Overrides the FSM decision when the slave has stalled for too long.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_IDLE) begin
      wait_cnt_d = '0;
    end else if (stalled) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end
`endif

  logic [1:0]  state_f;
  logic [1:0]  htrans_f;
  logic        cpu_done_f;
  logic        cpu_err_f;
  logic [31:0] cpu_rdata_f;

  always_comb begin
    state_f     = state_d;
    htrans_f    = htrans_d;
    cpu_done_f  = cpu_done_d;
    cpu_err_f   = cpu_err_d;
    cpu_rdata_f = cpu_rdata_d;
`ifdef AHB_MST_TIMEOUT_EN
    if (stalled && (wait_cnt_q == CNT_LAST)) begin
      state_f     = ST_RESP;
      htrans_f    = TR_IDLE;
      cpu_done_f  = 1'b1;
      cpu_err_f   = 1'b1;
      cpu_rdata_f = '0;
    end
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      haddr_q     <= '0;
      htrans_q    <= TR_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      err_acc_q   <= 1'b0;
      cpu_busy_q  <= 1'b0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= '0;
`ifdef AHB_MST_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_f;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_f;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      err_acc_q   <= err_acc_d;
      cpu_busy_q  <= cpu_busy_d;
      cpu_done_q  <= cpu_done_f;
      cpu_err_q   <= cpu_err_f;
      cpu_rdata_q <= cpu_rdata_f;
`ifdef AHB_MST_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign ahb.HADDR  = haddr_q;
  assign ahb.HTRANS = htrans_q;
  assign ahb.HWRITE = hwrite_q;
  assign ahb.HSIZE  = hsize_q;
  assign ahb.HBURST = 3'b000;
  assign ahb.HWDATA = hwdata_q;

  assign cpu_busy  = cpu_busy_q;
  assign cpu_done  = cpu_done_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_master
//  Directed bench for ahb_lite_master. A table of zero-wait transactions is
//  replayed cycle by cycle, followed by hand-written sequences for wait
//  states, sticky error response, mid-transfer reset and (when the timeout
//  feature is compiled in) the stuck-slave timeout.
// ---------------------------------------------------------------------------
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cpu_req;
  logic        cpu_wr;
  logic [2:0]  cpu_size;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata;

  int checks = 0;
  int passed = 0;

  ahb_lite_master_if #(.ADDR_W(8)) bus ();

  ahb_lite_master #(
    .ADDR_W      (8),
    .TIMEOUT_CYC (4)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_size  (cpu_size),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_busy  (cpu_busy),
    .cpu_done  (cpu_done),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .ahb       (bus.master)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        mis;
    logic [31:0] exp_hwdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] size,
                           input logic [7:0] addr, input logic [31:0] wdata);
    cpu_req   = 1'b1;
    cpu_wr    = wr;
    cpu_size  = size;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_vec(input int idx, input vec_t v);
    drive_req(v.wr, v.size, v.addr, v.wdata);
    bus.HREADY = 1'b1;
    bus.HRDATA = v.hrdata;
    bus.HRESP  = v.hresp;
    @(negedge HCLK);
    if (v.mis) begin
      chk("mis_htrans", {30'h0, bus.HTRANS}, 32'h0);
      chk("mis_done",   {31'h0, cpu_done},   32'h1);
      chk("mis_err",    {31'h0, cpu_err},    32'h1);
      cpu_req = 1'b0;
      @(negedge HCLK);
      chk("mis_htrans2", {30'h0, bus.HTRANS}, 32'h0);
      chk("mis_done_clr", {31'h0, cpu_done},  32'h0);
      chk("mis_busy_clr", {31'h0, cpu_busy},  32'h0);
    end else begin
      chk("addr_htrans", {30'h0, bus.HTRANS}, 32'h2);
      chk("addr_haddr",  {24'h0, bus.HADDR},  {24'h0, v.addr});
      chk("addr_hwrite", {31'h0, bus.HWRITE}, {31'h0, v.wr});
      chk("addr_hsize",  {29'h0, bus.HSIZE},  {29'h0, v.size});
      chk("addr_busy",   {31'h0, cpu_busy},   32'h1);
      chk("addr_done",   {31'h0, cpu_done},   32'h0);
      @(negedge HCLK);
      chk("data_htrans", {30'h0, bus.HTRANS}, 32'h0);
      chk("data_done",   {31'h0, cpu_done},   32'h0);
      if (v.wr) chk("data_hwdata", bus.HWDATA, v.exp_hwdata);
      @(negedge HCLK);
      chk("resp_done",  {31'h0, cpu_done}, 32'h1);
      chk("resp_err",   {31'h0, cpu_err},  {31'h0, v.exp_err});
      chk("resp_rdata", cpu_rdata, v.exp_rdata);
      cpu_req = 1'b0;
      @(negedge HCLK);
      chk("idle_done", {31'h0, cpu_done}, 32'h0);
      chk("idle_busy", {31'h0, cpu_busy}, 32'h0);
    end
    $display("txn %0d: wr=%0d size=%0d addr=0x%02h err=%0d rdata=0x%08h",
             idx, v.wr, v.size, v.addr, cpu_err, cpu_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;

    //       wr    size    addr   wdata         hrdata        hresp mis  exp_hwdata    err  exp_rdata
    vecs[0]  = '{1'b1, 3'b010, 8'h40, 32'hDEADBEEF, 32'h00000000, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 3'b010, 8'h40, 32'h00000000, 32'hDEADBEEF, 2'b00, 1'b0, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 3'b000, 8'h13, 32'hFF1234A5, 32'h00000000, 2'b00, 1'b0, 32'hA5A5A5A5, 1'b0, 32'h00000000};
    vecs[3]  = '{1'b0, 3'b000, 8'h13, 32'h00000000, 32'hA5112233, 2'b00, 1'b0, 32'h00000000, 1'b0, 32'h000000A5};
    vecs[4]  = '{1'b1, 3'b001, 8'h22, 32'hABCDBEEF, 32'h00000000, 2'b00, 1'b0, 32'hBEEFBEEF, 1'b0, 32'h00000000};
    vecs[5]  = '{1'b0, 3'b001, 8'h22, 32'h00000000, 32'h55667788, 2'b00, 1'b0, 32'h00000000, 1'b0, 32'h00005566};
    vecs[6]  = '{1'b0, 3'b000, 8'h11, 32'h00000000, 32'h11223344, 2'b00, 1'b0, 32'h00000000, 1'b0, 32'h00000033};
    vecs[7]  = '{1'b0, 3'b001, 8'h01, 32'h00000000, 32'hFFFFFFFF, 2'b00, 1'b1, 32'h00000000, 1'b1, 32'h00000000};
    vecs[8]  = '{1'b1, 3'b010, 8'h42, 32'h12345678, 32'h00000000, 2'b00, 1'b1, 32'h00000000, 1'b1, 32'h00000000};
    vecs[9]  = '{1'b0, 3'b011, 8'h00, 32'h00000000, 32'hFFFFFFFF, 2'b00, 1'b1, 32'h00000000, 1'b1, 32'h00000000};
    vecs[10] = '{1'b0, 3'b010, 8'h80, 32'h00000000, 32'h0BADF00D, 2'b10, 1'b0, 32'h00000000, 1'b1, 32'h0BADF00D};
    vecs[11] = '{1'b1, 3'b000, 8'h03, 32'h0000007E, 32'h00000000, 2'b11, 1'b0, 32'h7E7E7E7E, 1'b1, 32'h00000000};
    vecs[12] = '{1'b0, 3'b000, 8'hFF, 32'h00000000, 32'h9A000000, 2'b00, 1'b0, 32'h00000000, 1'b0, 32'h0000009A};
    vecs[13] = '{1'b0, 3'b001, 8'h00, 32'h00000000, 32'h12345678, 2'b00, 1'b0, 32'h00000000, 1'b0, 32'h00005678};

    HRESETn    = 1'b0;
    cpu_req    = 1'b0;
    cpu_wr     = 1'b0;
    cpu_size   = 3'b000;
    cpu_addr   = 8'h00;
    cpu_wdata  = 32'h0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 2'b00;
    bus.HRDATA = 32'h0;

    // Reset state
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_htrans", {30'h0, bus.HTRANS}, 32'h0);
    chk("rst_haddr",  {24'h0, bus.HADDR},  32'h0);
    chk("rst_hwrite", {31'h0, bus.HWRITE}, 32'h0);
    chk("rst_hsize",  {29'h0, bus.HSIZE},  32'h0);
    chk("rst_hburst", {29'h0, bus.HBURST}, 32'h0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_busy",   {31'h0, cpu_busy},  32'h0);
    chk("rst_done",   {31'h0, cpu_done},  32'h0);
    chk("rst_err",    {31'h0, cpu_err},   32'h0);
    chk("rst_rdata",  cpu_rdata, 32'h0);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Three data-phase wait states on a word write
    drive_req(1'b1, 3'b010, 8'h20, 32'h12345678);
    bus.HREADY = 1'b1;
    bus.HRESP  = 2'b00;
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge HCLK);
      if (cpu_done) pulses++;
      if (c >= 2 && c <= 5) begin
        chk("ws_htrans", {30'h0, bus.HTRANS}, 32'h0);
        chk("ws_haddr",  {24'h0, bus.HADDR},  32'h20);
        chk("ws_hwdata", bus.HWDATA, 32'h12345678);
      end
      if (c == 6) begin
        chk("ws_done", {31'h0, cpu_done}, 32'h1);
        chk("ws_err",  {31'h0, cpu_err},  32'h0);
        cpu_req = 1'b0;
      end
      bus.HREADY = !(c >= 2 && c <= 4);
    end
    chk("ws_pulses", pulses, 1);
    $display("txn ws: word write 0x20 with 3 wait states, done pulses=%0d", pulses);

    // ADDR stall, then ERROR on a wait cycle followed by OKAY: error must stick
    drive_req(1'b0, 3'b010, 8'h44, 32'h0);
    bus.HREADY = 1'b0;
    bus.HRDATA = 32'hCAFEF00D;
    @(negedge HCLK);
    chk("er_addr_htrans", {30'h0, bus.HTRANS}, 32'h2);
    @(negedge HCLK);
    chk("er_hold_htrans", {30'h0, bus.HTRANS}, 32'h2);
    chk("er_hold_haddr",  {24'h0, bus.HADDR},  32'h44);
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    chk("er_data_htrans", {30'h0, bus.HTRANS}, 32'h0);
    bus.HREADY = 1'b0;
    bus.HRESP  = 2'b01;
    @(negedge HCLK);
    chk("er_wait_done", {31'h0, cpu_done}, 32'h0);
    bus.HREADY = 1'b1;
    bus.HRESP  = 2'b00;
    @(negedge HCLK);
    chk("er_done", {31'h0, cpu_done}, 32'h1);
    chk("er_err",  {31'h0, cpu_err},  32'h1);
    cpu_req = 1'b0;
    @(negedge HCLK);
    chk("er_done_clr", {31'h0, cpu_done}, 32'h0);
    $display("txn er: word read 0x44 with sticky error, err seen");

    // Reset pulsed in the middle of a data phase
    drive_req(1'b1, 3'b010, 8'h48, 32'h55AA55AA);
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    bus.HREADY = 1'b0;
    #2 HRESETn = 1'b0;
    #1;
    chk("mr_htrans", {30'h0, bus.HTRANS}, 32'h0);
    chk("mr_haddr",  {24'h0, bus.HADDR},  32'h0);
    chk("mr_hwdata", bus.HWDATA, 32'h0);
    chk("mr_busy",   {31'h0, cpu_busy},  32'h0);
    chk("mr_done",   {31'h0, cpu_done},  32'h0);
    cpu_req = 1'b0;
    @(negedge HCLK);
    HRESETn    = 1'b1;
    bus.HREADY = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge HCLK);
      if (cpu_done || cpu_busy) pulses++;
    end
    chk("mr_no_done", pulses, 0);
    $display("txn mr: reset mid data phase, activity after reset=%0d", pulses);

`ifdef AHB_MST_TIMEOUT_EN
    // Slave never raises HREADY: abandoned after TIMEOUT_CYC=4 wait cycles
    drive_req(1'b0, 3'b010, 8'h50, 32'h0);
    bus.HREADY = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge HCLK);
      chk("to_htrans", {30'h0, bus.HTRANS}, 32'h2);
      chk("to_wait_done", {31'h0, cpu_done}, 32'h0);
    end
    @(negedge HCLK);
    chk("to_done",   {31'h0, cpu_done},  32'h1);
    chk("to_err",    {31'h0, cpu_err},   32'h1);
    chk("to_rdata",  cpu_rdata, 32'h0);
    chk("to_htrans_idle", {30'h0, bus.HTRANS}, 32'h0);
    cpu_req    = 1'b0;
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    $display("txn to: word read 0x50 timed out");
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
